// File: rtl/biu_constants_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : biu_constants_pkg
//  Description : Bus-interface constants shared by the LSU and the data TCM:
//                access-size encoding and the byte-lane enable helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package biu_constants_pkg;

    // Access size as presented on the data bus
    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HWORD = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011
    } biu_size_t;

    // Byte-lane mask for a 32-bit bus. Misaligned combinations still produce a
    // mask, but callers are expected to suppress the access in that case.
    function automatic logic [3:0] be_mask(input biu_size_t size, input logic [1:0] adr_lsb);
        logic [3:0] mask;
        case (size)
            BYTE:    mask = 4'b0001 << adr_lsb;
            HWORD:   mask = 4'b0011 << adr_lsb;
            WORD:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_dmem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_dmem_ram
//  Description : Single-port word RAM with byte write enables and a registered
//                read port whose output is cleared when no read is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_dmem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          re_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   d_i,
    output logic [31:0]   q_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // Read data is only presented for the cycle after a read request
    always_comb begin
        rdata_d = '0;
        if (re_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    // Read register; memory contents themselves are never reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Byte-lane write
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= d_i[8*i +: 8];
                end
            end
        end
    end

    assign q_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/riscv_dmem_tcm.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_dmem_tcm
//  Description : Data tightly-coupled memory with a req/ack bus, programmable
//                wait states, misalignment and out-of-window fault reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_dmem_tcm
    import biu_constants_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              DEPTH       = 1024,
    parameter logic [XLEN-1:0] BASE        = '0,
    parameter int              WAIT_STATES = 0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            dmem_req_i,
    input  logic            dmem_lock_i,
    input  logic [XLEN-1:0] dmem_adr_i,
    input  biu_size_t       dmem_size_i,
    input  logic            dmem_we_i,
    input  logic [XLEN-1:0] dmem_d_i,
    output logic [XLEN-1:0] dmem_q_o,
    output logic            dmem_ack_o,
    output logic            dmem_misaligned_o,
    output logic            dmem_page_fault_o
);

    localparam int         AW          = $clog2(DEPTH);
    localparam logic [3:0] C_WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] adr_q, adr_d;
    logic [XLEN-1:0] d_q, d_d;
    biu_size_t       size_q, size_d;
    logic            we_q, we_d;
    logic            lock_q, lock_d;
    logic            ack_q, ack_d;
    logic            mis_q, mis_d;
    logic            pf_q, pf_d;

    logic [XLEN-1:0] cur_adr;
    biu_size_t       cur_size;
    logic            cur_we;
    logic [XLEN-1:0] cur_off;
    logic            cur_mis;
    logic            cur_pf;
    logic            cur_err;

    logic            ram_re;
    logic            ram_we;
    logic [3:0]      ram_be;
    logic [XLEN-1:0] ram_q;
    logic            unused_bits;

    // The request under evaluation: live inputs in IDLE, captured copy after
    always_comb begin
        cur_adr  = adr_q;
        cur_size = size_q;
        cur_we   = we_q;
        if (state_q == S_IDLE) begin
            cur_adr  = dmem_adr_i;
            cur_size = dmem_size_i;
            cur_we   = dmem_we_i;
        end
        case (cur_size)
            HWORD:   cur_mis = cur_adr[0];
            WORD:    cur_mis = |cur_adr[1:0];
            DWORD:   cur_mis = 1'b1;
            default: cur_mis = 1'b0;
        endcase
        // BASE is aligned to the window size, so any set bit above the
        // window index means the address falls outside it (either side).
        cur_off = cur_adr - BASE;
        cur_pf  = !cur_mis && (|cur_off[XLEN-1:AW+2]);
        cur_err = cur_mis || cur_pf;
    end

    // Next-state, request capture and registered response flags
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        d_d     = d_q;
        size_d  = size_q;
        we_d    = we_q;
        lock_d  = lock_q;
        case (state_q)
            S_IDLE: begin
                if (dmem_req_i) begin
                    adr_d  = dmem_adr_i;
                    d_d    = dmem_d_i;
                    size_d = dmem_size_i;
                    we_d   = dmem_we_i;
                    lock_d = dmem_lock_i;
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = C_WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!dmem_req_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ack_d = (state_d == S_ACK);
        mis_d = ack_d && cur_mis;
        pf_d  = ack_d && cur_pf;
    end

    // Read is launched on the transition into ACK so data lines up with ack;
    // writes commit only at the end of the ACK cycle.
    always_comb begin
        ram_re = ack_d && !cur_we && !cur_err;
        ram_we = rst_ni && (state_q == S_ACK) && we_q && !(mis_q || pf_q);
        ram_be = be_mask(size_q, adr_q[1:0]);
    end

    // State and response registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            d_q     <= '0;
            size_q  <= BYTE;
            we_q    <= 1'b0;
            lock_q  <= 1'b0;
            ack_q   <= 1'b0;
            mis_q   <= 1'b0;
            pf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            d_q     <= d_d;
            size_q  <= size_d;
            we_q    <= we_d;
            lock_q  <= lock_d;
            ack_q   <= ack_d;
            mis_q   <= mis_d;
            pf_q    <= pf_d;
        end
    end

    riscv_dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .re_i   (ram_re),
        .we_i   (ram_we),
        .be_i   (ram_be),
        .addr_i (cur_off[AW+1:2]),
        .d_i    (d_q),
        .q_o    (ram_q)
    );

    // Lock is captured for the bus protocol only; single initiator, no effect
    assign unused_bits = ^{lock_q, cur_off[1:0]};

    assign dmem_q_o          = ram_q;
    assign dmem_ack_o        = ack_q;
    assign dmem_misaligned_o = mis_q;
    assign dmem_page_fault_o = pf_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_dmem_tcm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_dmem_tcm
//  Description : Self-checking bench for riscv_dmem_tcm. Unit 0 has no wait
//                states, unit 1 has three. A word-array model predicts every
//                response; literal expectations pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_dmem_tcm;
    import biu_constants_pkg::*;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] TOP   = BASE + DEPTH * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        req   [2];
    logic        lock  [2];
    logic        we    [2];
    logic [31:0] adr   [2];
    logic [31:0] d     [2];
    biu_size_t   size  [2];
    logic [31:0] q     [2];
    logic        ack   [2];
    logic        mis   [2];
    logic        pf    [2];

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    logic chk_en = 1'b0;

    logic [31:0] mmem     [2][DEPTH];
    int          exp_edge [2];
    logic [31:0] exp_q    [2];
    logic        exp_mis  [2];
    logic        exp_pf   [2];
    logic [31:0] last_q   [2];
    logic        last_mis [2];
    logic        last_pf  [2];

    riscv_dmem_tcm #(.XLEN(32), .DEPTH(DEPTH), .BASE(BASE), .WAIT_STATES(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .dmem_req_i(req[0]), .dmem_lock_i(lock[0]),
        .dmem_adr_i(adr[0]), .dmem_size_i(size[0]), .dmem_we_i(we[0]), .dmem_d_i(d[0]),
        .dmem_q_o(q[0]), .dmem_ack_o(ack[0]), .dmem_misaligned_o(mis[0]),
        .dmem_page_fault_o(pf[0])
    );

    riscv_dmem_tcm #(.XLEN(32), .DEPTH(DEPTH), .BASE(BASE), .WAIT_STATES(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n[1]), .dmem_req_i(req[1]), .dmem_lock_i(lock[1]),
        .dmem_adr_i(adr[1]), .dmem_size_i(size[1]), .dmem_we_i(we[1]), .dmem_d_i(d[1]),
        .dmem_q_o(q[1]), .dmem_ack_o(ack[1]), .dmem_misaligned_o(mis[1]),
        .dmem_page_fault_o(pf[1])
    );

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, expv);
        end
    endtask

    function automatic logic model_mis(input logic [31:0] a, input biu_size_t s);
        return (s == HWORD && (a % 2) != 0) || (s == WORD && (a % 4) != 0) || (s == DWORD);
    endfunction

    function automatic logic model_pf(input logic [31:0] a);
        return (longint'(a) < longint'(BASE)) || (longint'(a) >= longint'(BASE) + DEPTH * 4);
    endfunction

    // Every cycle: ack only where the model predicts it, q zero elsewhere
    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                if (edge_n == exp_edge[u]) begin
                    check($sformatf("u%0d ack", u), {31'b0, ack[u]}, 32'd1);
                    check($sformatf("u%0d q", u), q[u], exp_q[u]);
                    check($sformatf("u%0d misaligned", u), {31'b0, mis[u]}, {31'b0, exp_mis[u]});
                    check($sformatf("u%0d page_fault", u), {31'b0, pf[u]}, {31'b0, exp_pf[u]});
                end else begin
                    check($sformatf("u%0d idle ack", u), {31'b0, ack[u]}, 32'd0);
                    check($sformatf("u%0d idle q", u), q[u], 32'd0);
                end
                if (ack[u]) begin
                    last_q[u]   <= q[u];
                    last_mis[u] <= mis[u];
                    last_pf[u]  <= pf[u];
                end
            end
        end
    end

    // One access on unit u; drop_after / rst_after > 0 abort it in WAIT
    task automatic access(input int u, input logic [31:0] a, input biu_size_t s,
                          input logic w, input logic [31:0] wd,
                          input int drop_after, input int rst_after);
        int ws;
        int acc;
        int idx;
        int nb;
        logic m;
        logic p;
        logic [31:0] word;
        ws = (u == 0) ? 0 : 3;
        @(posedge clk); #1;
        req[u]  = 1'b1;
        adr[u]  = a;
        size[u] = s;
        we[u]   = w;
        d[u]    = wd;
        lock[u] = 1'($urandom_range(0, 1));
        acc = edge_n + 1;
        m = model_mis(a, s);
        p = !m && model_pf(a);
        idx = (m || p) ? 0 : int'((a - BASE) >> 2);
        if (drop_after == 0 && rst_after == 0) begin
            exp_edge[u] = acc + ws;
            exp_mis[u]  = m;
            exp_pf[u]   = p;
            exp_q[u]    = (m || p || w) ? 32'd0 : mmem[u][idx];
            repeat (ws + 1) @(posedge clk);
            #1 req[u] = 1'b0;
            if (!m && !p && w) begin
                nb   = (s == BYTE) ? 1 : (s == HWORD) ? 2 : 4;
                word = mmem[u][idx];
                for (int b = 0; b < 4; b++) begin
                    if (b >= int'(a % 4) && b < int'(a % 4) + nb) word[8*b +: 8] = wd[8*b +: 8];
                end
                mmem[u][idx] = word;
            end
            @(negedge clk); #1;
        end else if (drop_after > 0) begin
            repeat (drop_after + 1) @(posedge clk);
            #1 req[u] = 1'b0;
            repeat (ws + 2) @(posedge clk);
            @(negedge clk); #1;
        end else begin
            repeat (rst_after + 1) @(posedge clk);
            #1;
            req[u]   = 1'b0;
            rst_n[u] = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("reset mid ack", {31'b0, ack[u]}, 32'd0);
            check("reset mid q", q[u], 32'd0);
            check("reset mid misaligned", {31'b0, mis[u]}, 32'd0);
            check("reset mid page_fault", {31'b0, pf[u]}, 32'd0);
            rst_n[u] = 1'b1;
            repeat (ws + 2) @(posedge clk);
            @(negedge clk); #1;
        end
    endtask

    task automatic lit(input int u, input string name, input logic [31:0] eq,
                       input logic em, input logic ep);
        check({name, " q"}, last_q[u], eq);
        check({name, " misaligned"}, {31'b0, last_mis[u]}, {31'b0, em});
        check({name, " page_fault"}, {31'b0, last_pf[u]}, {31'b0, ep});
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; req[u] = 1'b0; lock[u] = 1'b0; we[u] = 1'b0;
            adr[u] = '0; d[u] = '0; size[u] = WORD; exp_edge[u] = -1;
            for (int i = 0; i < DEPTH; i++) mmem[u][i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("reset ack", {31'b0, ack[u]}, 32'd0);
            check("reset q", q[u], 32'd0);
            check("reset misaligned", {31'b0, mis[u]}, 32'd0);
            check("reset page_fault", {31'b0, pf[u]}, 32'd0);
            rst_n[u] = 1'b1;
        end
        chk_en = 1'b1;

        // Zero wait states
        access(0, BASE + 8, WORD, 1'b1, 32'hDEAD_BEEF, 0, 0);
        access(0, BASE + 8, WORD, 1'b0, 32'h0, 0, 0);
        lit(0, "word rd", 32'hDEAD_BEEF, 1'b0, 1'b0);
        access(0, BASE + 9, BYTE, 1'b1, 32'h0000_AA00, 0, 0);
        access(0, BASE + 8, WORD, 1'b0, 32'h0, 0, 0);
        lit(0, "byte merge", 32'hDEAD_AAEF, 1'b0, 1'b0);
        access(0, BASE + 3, HWORD, 1'b0, 32'h0, 0, 0);
        lit(0, "hword mis", 32'h0, 1'b1, 1'b0);
        access(0, BASE + 10, WORD, 1'b1, 32'hFFFF_FFFF, 0, 0);
        lit(0, "word wr mis", 32'h0, 1'b1, 1'b0);
        access(0, BASE + 8, WORD, 1'b0, 32'h0, 0, 0);
        lit(0, "unchanged", 32'hDEAD_AAEF, 1'b0, 1'b0);
        access(0, TOP, WORD, 1'b0, 32'h0, 0, 0);
        lit(0, "above window", 32'h0, 1'b0, 1'b1);
        access(0, BASE - 4, WORD, 1'b0, 32'h0, 0, 0);
        lit(0, "below window", 32'h0, 1'b0, 1'b1);
        access(0, TOP + 1, HWORD, 1'b0, 32'h0, 0, 0);
        lit(0, "mis priority", 32'h0, 1'b1, 1'b0);
        access(0, BASE + 8, DWORD, 1'b0, 32'h0, 0, 0);
        lit(0, "dword", 32'h0, 1'b1, 1'b0);
        access(0, BASE + 12, WORD, 1'b1, 32'h0, 0, 0);
        access(0, BASE + 14, HWORD, 1'b1, 32'h1234_0000, 0, 0);
        access(0, BASE + 12, WORD, 1'b0, 32'h0, 0, 0);
        lit(0, "upper hword", 32'h1234_0000, 1'b0, 1'b0);
        access(0, TOP - 4, WORD, 1'b1, 32'hCAFE_F00D, 0, 0);
        access(0, TOP - 4, WORD, 1'b0, 32'h0, 0, 0);
        lit(0, "last word", 32'hCAFE_F00D, 1'b0, 1'b0);
        access(0, BASE + 9, BYTE, 1'b0, 32'h0, 0, 0);
        lit(0, "byte rd full word", 32'hDEAD_AAEF, 1'b0, 1'b0);

        // Three wait states
        access(1, BASE, WORD, 1'b1, 32'h1122_3344, 0, 0);
        access(1, BASE, WORD, 1'b0, 32'h0, 0, 0);
        lit(1, "ws3 rd", 32'h1122_3344, 1'b0, 1'b0);
        access(1, BASE, WORD, 1'b1, 32'h5566_7788, 2, 0);
        access(1, BASE, WORD, 1'b0, 32'h0, 0, 0);
        lit(1, "after abort", 32'h1122_3344, 1'b0, 1'b0);
        access(1, BASE, WORD, 1'b0, 32'h0, 0, 1);
        access(1, BASE, WORD, 1'b0, 32'h0, 0, 0);
        lit(1, "after reset", 32'h1122_3344, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
